// File: rtl/sram_ctrl.sv
// Wishbone classic slave for a 32-bit asynchronous SRAM with programmable read and
// write wait states; partial-lane writes are done as read-modify-write.
module sram_ctrl #(
   parameter int unsigned READ_WAIT  = 2,
   parameter int unsigned WRITE_WAIT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wishbone_cyc_i,
   input  logic        wishbone_stb_i,
   input  logic        wishbone_we_i,
   input  logic [31:0] wishbone_addr_i,
   input  logic [3:0]  wishbone_sel_i,
   input  logic [31:0] wishbone_data_i,
   output logic [31:0] wishbone_data_o,
   output logic        wishbone_ack_o,
   output logic [19:0] sram_addr,
   inout  wire  [31:0] sram_data,
   output logic        sram_ce,
   output logic        sram_oe,
   output logic        sram_we
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WR   = 3'd2,
      WREC = 3'd3,
      ACK  = 3'd4
   } state_t;

   localparam logic [3:0] RD_LAST = 4'(READ_WAIT - 1);
   localparam logic [3:0] WR_LAST = 4'(WRITE_WAIT - 1);

   state_t      state;
   logic [3:0]  cnt;
   logic        is_write;
   logic        dropped;
   logic        drive;
   logic [3:0]  sel;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        unused_addr;

   function automatic logic [31:0] merge_lanes(input logic [31:0] new_word,
                                                input logic [31:0] old_word,
                                                input logic [3:0]  lanes);
      logic [31:0] mask;
      mask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
      return (new_word & mask) | (old_word & ~mask);
   endfunction

   assign sram_data   = drive ? wdata : 32'bz;
   assign unused_addr = ^{wishbone_addr_i[31:22], wishbone_addr_i[1:0]};

   // Transfer sequencer; every SRAM strobe and bus output is a register set here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         cnt             <= 4'd0;
         is_write        <= 1'b0;
         dropped         <= 1'b0;
         drive           <= 1'b0;
         sel             <= 4'd0;
         wdata           <= 32'd0;
         rdata           <= 32'd0;
         sram_addr       <= 20'd0;
         sram_ce         <= 1'b1;
         sram_oe         <= 1'b1;
         sram_we         <= 1'b1;
         wishbone_ack_o  <= 1'b0;
         wishbone_data_o <= 32'd0;
      end else begin
         wishbone_ack_o <= 1'b0;
         case (state)
            IDLE: begin
               sram_ce <= 1'b1;
               sram_oe <= 1'b1;
               sram_we <= 1'b1;
               drive   <= 1'b0;
               // The still-visible ack of the previous transfer blocks re-acceptance.
               if (wishbone_cyc_i && wishbone_stb_i && !wishbone_ack_o) begin
                  sram_addr <= wishbone_addr_i[21:2];
                  wdata     <= wishbone_data_i;
                  sel       <= wishbone_sel_i;
                  is_write  <= wishbone_we_i;
                  dropped   <= 1'b0;
                  cnt       <= 4'd0;
                  sram_ce   <= 1'b0;
                  if (wishbone_we_i && (wishbone_sel_i == 4'b1111)) begin
                     state   <= WR;
                     sram_we <= 1'b0;
                     drive   <= 1'b1;
                  end else begin
                     state   <= RD;
                     sram_oe <= 1'b0;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            RD: begin
               if (!wishbone_cyc_i) begin
                  state   <= IDLE;
                  cnt     <= 4'd0;
                  sram_ce <= 1'b1;
                  sram_oe <= 1'b1;
               end else if (cnt == RD_LAST) begin
                  rdata   <= sram_data;
                  cnt     <= 4'd0;
                  sram_oe <= 1'b1;
                  if (is_write) begin
                     wdata   <= merge_lanes(wdata, sram_data, sel);
                     sram_we <= 1'b0;
                     drive   <= 1'b1;
                     state   <= WR;
                  end else begin
                     sram_ce <= 1'b1;
                     state   <= ACK;
                  end
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            WR: begin
               dropped <= dropped | ~wishbone_cyc_i;
               if (cnt == WR_LAST) begin
                  cnt     <= 4'd0;
                  sram_we <= 1'b1;
                  sram_ce <= 1'b1;
                  state   <= WREC;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            WREC: begin
               // Data stayed on the bus one cycle past the rising we edge for hold time.
               dropped <= dropped | ~wishbone_cyc_i;
               drive   <= 1'b0;
               state   <= ACK;
            end
            ACK: begin
               state <= IDLE;
               if (!dropped && wishbone_cyc_i) begin
                  wishbone_ack_o <= 1'b1;
                  if (!is_write) begin
                     wishbone_data_o <= rdata;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               cnt     <= 4'd0;
               drive   <= 1'b0;
               sram_ce <= 1'b1;
               sram_oe <= 1'b1;
               sram_we <= 1'b1;
            end
         endcase
      end
   end

endmodule
